// File: rtl/spi_ram_pkg.sv
// Shared constants and types for the SPI/host RAM command arbiter.
package spi_ram_pkg;

  localparam int unsigned CMD_W  = 10;
  localparam int unsigned DATA_W = 8;

  localparam logic [1:0] OP_WR_ADDR = 2'b00;
  localparam logic [1:0] OP_WR_DATA = 2'b01;
  localparam logic [1:0] OP_RD_ADDR = 2'b10;
  localparam logic [1:0] OP_RD_DATA = 2'b11;

  typedef enum logic [1:0] {
    IDLE,
    LOCK,
    WAIT_RD
  } state_e;

endpackage

// File: rtl/spi_ram_arbiter_rr_grant2.sv
// Two-way round-robin grant: a lone requester always wins, a tie goes to rr_ptr_i.
module rr_grant2 (
  input  logic [1:0] valid_i,
  input  logic       rr_ptr_i,
  output logic [1:0] grant_o
);

  always_comb begin
    grant_o = valid_i;
    if (&valid_i) begin
      grant_o = rr_ptr_i ? 2'b10 : 2'b01;
    end
  end

endmodule

// File: rtl/spi_ram_arbiter.sv
// Arbitrates two requesters onto one RAM command port, holding ownership across
// address/data command pairs and routing read returns back to the issuer.
module spi_ram_arbiter
  import spi_ram_pkg::*;
#(
  parameter int unsigned LOCK_TIMEOUT = 64,
  parameter int unsigned RD_TIMEOUT   = 8,
  parameter int unsigned CNT_W        = 7
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [CMD_W-1:0]  req0_din,
  input  logic              req0_valid,
  output logic              req0_ready,
  output logic [DATA_W-1:0] rsp0_data,
  output logic              rsp0_valid,
  input  logic [CMD_W-1:0]  req1_din,
  input  logic              req1_valid,
  output logic              req1_ready,
  output logic [DATA_W-1:0] rsp1_data,
  output logic              rsp1_valid,
  output logic [CMD_W-1:0]  ram_din,
  output logic              ram_rx_valid,
  input  logic [DATA_W-1:0] ram_dout,
  input  logic              ram_tx_valid,
  output logic              err_timeout
);

  localparam logic [CNT_W-1:0] LockLast = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] RdLast   = CNT_W'(RD_TIMEOUT - 1);

  state_e                       state_q, state_d;
  logic                         owner_q, owner_d;
  logic                         rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0]             cnt_q, cnt_d;
  logic [CMD_W-1:0]             ram_din_q, ram_din_d;
  logic                         ram_rx_valid_q, ram_rx_valid_d;
  logic [1:0][DATA_W-1:0]       rsp_data_q, rsp_data_d;
  logic [1:0]                   rsp_valid_q, rsp_valid_d;
  logic                         err_q, err_d;

  logic [1:0]       req_valid, grant, ready, xfer;
  logic             src;
  logic [CMD_W-1:0] word;
  logic [1:0]       op;

  assign req_valid = {req1_valid, req0_valid};

  rr_grant2 u_rr_grant2 (
    .valid_i  (req_valid),
    .rr_ptr_i (rr_ptr_q),
    .grant_o  (grant)
  );

  always_comb begin
    ready = 2'b00;
    unique case (state_q)
      IDLE:    ready = grant;
      LOCK:    ready[owner_q] = 1'b1;
      default: ready = 2'b00;
    endcase
  end

  assign xfer = ready & req_valid;
  assign src  = xfer[1];
  assign word = src ? req1_din : req0_din;
  assign op   = word[CMD_W-1 -: 2];

  always_comb begin
    state_d        = state_q;
    owner_d        = owner_q;
    rr_ptr_d       = rr_ptr_q;
    cnt_d          = cnt_q;
    ram_din_d      = ram_din_q;
    ram_rx_valid_d = 1'b0;
    rsp_data_d     = rsp_data_q;
    rsp_valid_d    = 2'b00;
    err_d          = 1'b0;

    if (|xfer) begin
      ram_din_d      = word;
      ram_rx_valid_d = 1'b1;
    end

    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (|xfer) begin
          owner_d = src;
          unique case (op)
            OP_WR_DATA: rr_ptr_d = ~src;  // stale-address write, no lock taken
            OP_RD_DATA: state_d  = WAIT_RD;
            default:    state_d  = LOCK;
          endcase
        end
      end
      LOCK: begin
        if (|xfer) begin
          cnt_d = '0;
          unique case (op)
            OP_WR_DATA: begin
              state_d  = IDLE;
              rr_ptr_d = ~owner_q;
            end
            OP_RD_DATA: state_d = WAIT_RD;
            default:    state_d = LOCK;
          endcase
        end else if (cnt_q == LockLast) begin
          state_d  = IDLE;
          rr_ptr_d = ~owner_q;
          cnt_d    = '0;
          err_d    = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      WAIT_RD: begin
        // Returned data takes priority over a coinciding timeout boundary.
        if (ram_tx_valid || (cnt_q == RdLast)) begin
          rsp_data_d[owner_q]  = ram_tx_valid ? ram_dout : '0;
          rsp_valid_d[owner_q] = 1'b1;
          err_d                = ~ram_tx_valid;
          state_d              = IDLE;
          rr_ptr_d             = ~owner_q;
          cnt_d                = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      owner_q        <= 1'b0;
      rr_ptr_q       <= 1'b0;
      cnt_q          <= '0;
      ram_din_q      <= '0;
      ram_rx_valid_q <= 1'b0;
      rsp_data_q     <= '0;
      rsp_valid_q    <= 2'b00;
      err_q          <= 1'b0;
    end else begin
      state_q        <= state_d;
      owner_q        <= owner_d;
      rr_ptr_q       <= rr_ptr_d;
      cnt_q          <= cnt_d;
      ram_din_q      <= ram_din_d;
      ram_rx_valid_q <= ram_rx_valid_d;
      rsp_data_q     <= rsp_data_d;
      rsp_valid_q    <= rsp_valid_d;
      err_q          <= err_d;
    end
  end

  assign req0_ready   = ready[0];
  assign req1_ready   = ready[1];
  assign ram_din      = ram_din_q;
  assign ram_rx_valid = ram_rx_valid_q;
  assign rsp0_data    = rsp_data_q[0];
  assign rsp1_data    = rsp_data_q[1];
  assign rsp0_valid   = rsp_valid_q[0];
  assign rsp1_valid   = rsp_valid_q[1];
  assign err_timeout  = err_q;

endmodule

// File: tb/tb_spi_ram_arbiter.sv
// Self-checking bench for spi_ram_arbiter: vector table, directed corner cases and
// randomized traffic against a transaction-level reference model.
module tb_spi_ram_arbiter;

  localparam int LockTo = 64;
  localparam int RdTo   = 8;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [9:0] req0_din, req1_din, ram_din;
  logic       req0_valid, req1_valid, req0_ready, req1_ready;
  logic [7:0] rsp0_data, rsp1_data, ram_dout;
  logic       rsp0_valid, rsp1_valid, ram_rx_valid, ram_tx_valid, err_timeout;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  spi_ram_arbiter #(
    .LOCK_TIMEOUT (LockTo),
    .RD_TIMEOUT   (RdTo),
    .CNT_W        (7)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req0_din     (req0_din),
    .req0_valid   (req0_valid),
    .req0_ready   (req0_ready),
    .rsp0_data    (rsp0_data),
    .rsp0_valid   (rsp0_valid),
    .req1_din     (req1_din),
    .req1_valid   (req1_valid),
    .req1_ready   (req1_ready),
    .rsp1_data    (rsp1_data),
    .rsp1_valid   (rsp1_valid),
    .ram_din      (ram_din),
    .ram_rx_valid (ram_rx_valid),
    .ram_dout     (ram_dout),
    .ram_tx_valid (ram_tx_valid),
    .err_timeout  (err_timeout)
  );

  typedef struct {
    logic       rst;
    logic       v0;
    logic [9:0] d0;
    logic       v1;
    logic [9:0] d1;
    logic       tx;
    logic [7:0] dout;
    logic       r0;
    logic       r1;
    logic       rx;
    logic [9:0] din;
    logic       s0v;
    logic [7:0] s0d;
    logic       s1v;
    logic [7:0] s1d;
    logic       err;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic apply(input logic rst, input logic v0, input logic [9:0] d0, input logic v1,
                       input logic [9:0] d1, input logic tx, input logic [7:0] dout);
    rst_n = rst; req0_valid = v0; req0_din = d0; req1_valid = v1; req1_din = d1;
    ram_tx_valid = tx; ram_dout = dout;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_cycle();
    apply(1'b1, 1'b0, 10'h000, 1'b0, 10'h000, 1'b0, 8'h00);
    tick();
  endtask

  task automatic do_reset();
    apply(1'b0, 1'b0, 10'h000, 1'b0, 10'h000, 1'b0, 8'h00);
    tick();
  endtask

  // Reference model: who holds the RAM, whether a read is outstanding, and idle age.
  int         m_holder;
  bit         m_reading;
  int         m_age;
  int         m_pref;
  logic [7:0] e_rsp_d [2];
  logic       e_rsp_v [2];
  logic       e_rx, e_err;
  logic [9:0] e_din;

  function automatic logic [1:0] model_ready();
    logic [1:0] r;
    r = 2'b00;
    if (m_reading) r = 2'b00;
    else if (m_holder >= 0) r[m_holder] = 1'b1;
    else if (req0_valid && req1_valid) r[m_pref] = 1'b1;
    else r = {req1_valid, req0_valid};
    return r;
  endfunction

  task automatic model_reset();
    m_holder = -1; m_reading = 0; m_age = 0; m_pref = 0;
    e_rsp_d[0] = 8'h00; e_rsp_d[1] = 8'h00; e_rsp_v[0] = 0; e_rsp_v[1] = 0;
    e_rx = 0; e_err = 0; e_din = 10'h000;
  endtask

  task automatic model_step(input logic [1:0] rdy);
    int who;
    logic [9:0] w;
    if (!rst_n) begin
      model_reset();
      return;
    end
    e_rx = 0; e_err = 0; e_rsp_v[0] = 0; e_rsp_v[1] = 0;
    if ((rdy[0] && req0_valid) || (rdy[1] && req1_valid)) begin
      who = (rdy[1] && req1_valid) ? 1 : 0;
      w = (who == 1) ? req1_din : req0_din;
      e_rx = 1; e_din = w; m_age = 0;
      case (int'(w >> 8))
        1: begin m_holder = -1; m_pref = 1 - who; end
        3: begin m_holder = who; m_reading = 1; end
        default: m_holder = who;
      endcase
    end else if (m_reading) begin
      if (ram_tx_valid || m_age == RdTo - 1) begin
        e_rsp_v[m_holder] = 1;
        e_rsp_d[m_holder] = ram_tx_valid ? ram_dout : 8'h00;
        e_err = !ram_tx_valid;
        m_pref = 1 - m_holder; m_holder = -1; m_reading = 0; m_age = 0;
      end else m_age++;
    end else if (m_holder >= 0) begin
      if (m_age == LockTo - 1) begin
        e_err = 1; m_pref = 1 - m_holder; m_holder = -1; m_age = 0;
      end else m_age++;
    end
  endtask

  vec_t tbl [14];

  initial begin
    logic [1:0] rdy;

    tbl[0]  = '{1'b1, 1'b1, 10'h0A5, 1'b0, 10'h000, 1'b0, 8'h00,
                1'b1, 1'b0, 1'b1, 10'h0A5, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0};
    tbl[1]  = '{1'b1, 1'b1, 10'h13C, 1'b0, 10'h000, 1'b0, 8'h00,
                1'b1, 1'b0, 1'b1, 10'h13C, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0};
    tbl[2]  = '{1'b1, 1'b1, 10'h210, 1'b1, 10'h020, 1'b0, 8'h00,
                1'b0, 1'b1, 1'b1, 10'h020, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0};
    tbl[3]  = '{1'b0, 1'b0, 10'h000, 1'b0, 10'h000, 1'b0, 8'h00,
                1'b0, 1'b1, 1'b0, 10'h000, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0};
    tbl[4]  = '{1'b1, 1'b1, 10'h210, 1'b1, 10'h020, 1'b0, 8'h00,
                1'b1, 1'b0, 1'b1, 10'h210, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0};
    tbl[5]  = '{1'b1, 1'b1, 10'h300, 1'b1, 10'h020, 1'b0, 8'h00,
                1'b1, 1'b0, 1'b1, 10'h300, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0};
    tbl[6]  = '{1'b1, 1'b1, 10'h300, 1'b1, 10'h020, 1'b0, 8'h00,
                1'b0, 1'b0, 1'b0, 10'h000, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0};
    tbl[7]  = '{1'b1, 1'b1, 10'h300, 1'b1, 10'h020, 1'b1, 8'h5A,
                1'b0, 1'b0, 1'b0, 10'h000, 1'b1, 8'h5A, 1'b0, 8'h00, 1'b0};
    tbl[8]  = '{1'b1, 1'b1, 10'h300, 1'b1, 10'h020, 1'b0, 8'h00,
                1'b0, 1'b1, 1'b1, 10'h020, 1'b0, 8'h5A, 1'b0, 8'h00, 1'b0};
    tbl[9]  = '{1'b1, 1'b1, 10'h300, 1'b1, 10'h140, 1'b0, 8'h00,
                1'b0, 1'b1, 1'b1, 10'h140, 1'b0, 8'h5A, 1'b0, 8'h00, 1'b0};
    tbl[10] = '{1'b1, 1'b0, 10'h000, 1'b0, 10'h000, 1'b1, 8'hFF,
                1'b0, 1'b0, 1'b0, 10'h000, 1'b0, 8'h5A, 1'b0, 8'h00, 1'b0};
    tbl[11] = '{1'b1, 1'b0, 10'h000, 1'b1, 10'h300, 1'b0, 8'h00,
                1'b0, 1'b1, 1'b1, 10'h300, 1'b0, 8'h5A, 1'b0, 8'h00, 1'b0};
    tbl[12] = '{1'b1, 1'b0, 10'h000, 1'b0, 10'h000, 1'b1, 8'h81,
                1'b0, 1'b0, 1'b0, 10'h000, 1'b0, 8'h5A, 1'b1, 8'h81, 1'b0};
    tbl[13] = '{1'b1, 1'b0, 10'h000, 1'b0, 10'h000, 1'b0, 8'h00,
                1'b0, 1'b0, 1'b0, 10'h000, 1'b0, 8'h5A, 1'b0, 8'h81, 1'b0};

    // Reset state
    do_reset();
    do_reset();
    chk("reset ram_rx_valid", 32'(ram_rx_valid), 0);
    chk("reset ram_din", 32'(ram_din), 0);
    chk("reset rsp0", 32'({rsp0_valid, rsp0_data}), 0);
    chk("reset rsp1", 32'({rsp1_valid, rsp1_data}), 0);
    chk("reset err", 32'(err_timeout), 0);

    // Vector table: write pair, contention, read return, reset in LOCK
    for (int i = 0; i < 14; i++) begin
      apply(tbl[i].rst, tbl[i].v0, tbl[i].d0, tbl[i].v1, tbl[i].d1, tbl[i].tx, tbl[i].dout);
      chk($sformatf("vec%0d req0_ready", i), 32'(req0_ready), 32'(tbl[i].r0));
      chk($sformatf("vec%0d req1_ready", i), 32'(req1_ready), 32'(tbl[i].r1));
      tick();
      chk($sformatf("vec%0d ram_rx_valid", i), 32'(ram_rx_valid), 32'(tbl[i].rx));
      if (tbl[i].rx) chk($sformatf("vec%0d ram_din", i), 32'(ram_din), 32'(tbl[i].din));
      chk($sformatf("vec%0d rsp0", i), 32'({rsp0_valid, rsp0_data}), 32'({tbl[i].s0v, tbl[i].s0d}));
      chk($sformatf("vec%0d rsp1", i), 32'({rsp1_valid, rsp1_data}), 32'({tbl[i].s1v, tbl[i].s1d}));
      chk($sformatf("vec%0d err", i), 32'(err_timeout), 32'(tbl[i].err));
    end

    // Lock timeout: req1 takes the lock then idles
    do_reset();
    apply(1'b1, 1'b0, 10'h000, 1'b1, 10'h040, 1'b0, 8'h00);
    chk("lockto take", 32'(req1_ready), 1);
    tick();
    for (int i = 1; i <= LockTo; i++) begin
      idle_cycle();
      if (i < LockTo) begin
        if (err_timeout !== 1'b0) chk($sformatf("lockto early err @%0d", i), 32'(err_timeout), 0);
      end else chk("lockto err pulse", 32'(err_timeout), 1);
    end
    apply(1'b1, 1'b1, 10'h0AA, 1'b1, 10'h055, 1'b0, 8'h00);
    chk("lockto req0 granted", 32'({req1_ready, req0_ready}), 32'(2'b01));
    tick();
    chk("lockto err cleared", 32'(err_timeout), 0);
    chk("lockto din", 32'(ram_din), 32'(10'h0AA));

    // Read timeout: RAM never answers
    do_reset();
    apply(1'b1, 1'b1, 10'h300, 1'b0, 10'h000, 1'b0, 8'h00);
    tick();
    for (int i = 1; i <= RdTo; i++) begin
      apply(1'b1, 1'b0, 10'h000, 1'b0, 10'h000, 1'b0, 8'h00);
      tick();
      if (i < RdTo) begin
        if (rsp0_valid !== 1'b0 || err_timeout !== 1'b0)
          chk($sformatf("rdto early @%0d", i), 32'({rsp0_valid, err_timeout}), 0);
      end else begin
        chk("rdto rsp0", 32'({rsp0_valid, rsp0_data}), 32'({1'b1, 8'h00}));
        chk("rdto err", 32'(err_timeout), 1);
      end
    end

    // Boundary: data on the last WAIT_RD cycle wins over the timeout
    apply(1'b1, 1'b1, 10'h300, 1'b0, 10'h000, 1'b0, 8'h00);
    tick();
    for (int i = 1; i <= RdTo; i++) begin
      apply(1'b1, 1'b0, 10'h000, 1'b0, 10'h000, i == RdTo, 8'hC3);
      tick();
    end
    chk("boundary rsp0", 32'({rsp0_valid, rsp0_data}), 32'({1'b1, 8'hC3}));
    chk("boundary err", 32'(err_timeout), 0);

    // Reset while waiting for read data: no response, rr_ptr back to 0
    apply(1'b1, 1'b0, 10'h000, 1'b1, 10'h300, 1'b0, 8'h00);
    tick();
    idle_cycle();
    apply(1'b0, 1'b0, 10'h000, 1'b0, 10'h000, 1'b1, 8'h77);
    tick();
    chk("rst wait rsp1", 32'({rsp1_valid, rsp1_data}), 0);
    chk("rst wait rsp0", 32'({rsp0_valid, rsp0_data}), 0);
    chk("rst wait rx/err", 32'({ram_rx_valid, err_timeout}), 0);
    apply(1'b1, 1'b1, 10'h011, 1'b1, 10'h022, 1'b0, 8'h00);
    chk("rst wait rr_ptr 0", 32'({req1_ready, req0_ready}), 32'(2'b01));
    tick();

    // Randomized traffic against the reference model
    for (int i = 0; i < 3000; i++) begin
      apply((i == 0) ? 1'b0 : ($urandom_range(0, 249) != 0),
            $urandom_range(0, 3) == 0, 10'($urandom_range(0, 1023)),
            $urandom_range(0, 3) == 0, 10'($urandom_range(0, 1023)),
            $urandom_range(0, 5) == 0, 8'($urandom_range(0, 255)));
      if (i != 0) begin
        rdy = model_ready();
        chk("rand ready", 32'({req1_ready, req0_ready}), 32'(rdy));
      end else rdy = 2'b00;
      model_step(rdy);
      tick();
      chk("rand rx", 32'(ram_rx_valid), 32'(e_rx));
      if (e_rx) chk("rand din", 32'(ram_din), 32'(e_din));
      chk("rand rsp0", 32'({rsp0_valid, rsp0_data}), 32'({e_rsp_v[0], e_rsp_d[0]}));
      chk("rand rsp1", 32'({rsp1_valid, rsp1_data}), 32'({e_rsp_v[1], e_rsp_d[1]}));
      chk("rand err", 32'(err_timeout), 32'(e_err));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
